load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter mem_depth, default 1024: number of 32-bit words in the attached RAM.
REQ-002 Parameter size, default 32: data and address width.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  size  byte address.
REQ-009 req_wdata  input  size  store data, right-aligned.
REQ-010 req_funct3  input  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (100/101 valid for loads only).
REQ-011 rsp_valid  output  1  one-cycle pulse; request complete.
REQ-012 rsp_rdata  output  size  load result, extended to size bits; 0 for stores and errors.
REQ-013 rsp_error  output  1  qualified by rsp_valid; request rejected.
REQ-014 mem_address  output  size  word index to RAM (req_addr[size-1:2]).
REQ-015 mem_data  output  size  write data to RAM.
REQ-016 mem_wren  output  1  RAM write enable; RAM writes on posedge clock.
REQ-017 mem_wread  output  1  RAM read enable; RAM read data is combinational.
REQ-018 mem_rdata  input  size  RAM read data, valid in the same cycle as mem_wread.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE, and RESP.
REQ-020 Acceptance SHALL occur on the posedge where req_valid and req_ready are both high; address, wdata, funct3 and write SHALL be latched at that edge.
REQ-021 Error conditions SHALL be: a half access with addr[0] set; a word access with addr[1:0] non-zero; funct3 011, 110 or 111; funct3 100 or 101 with write set; word index at or above mem_depth.
REQ-022 On an error the unit SHALL go IDLE->RESP with no RAM access, and assert rsp_error=1 and rsp_rdata=0.
REQ-023 A load SHALL go IDLE->READ->RESP: in READ, mem_wread=1, and the byte or half is selected by addr[1:0] (little-endian), extended and registered.
REQ-024 Extension SHALL be sign-extension for funct3 000/001 and zero-extension for funct3 100/101.
REQ-025 A word store SHALL go IDLE->WRITE->RESP: in WRITE, mem_wren=1 and mem_data=wdata.
REQ-026 A byte or half store SHALL go IDLE->READ->WRITE->RESP: the word read in READ is registered, wdata[7:0] or wdata[15:0] is merged into the lane selected by addr[1:0], and the merged word is written in WRITE.
REQ-027 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-028 req_ready SHALL be 0 in READ, WRITE and RESP, so a new request is accepted at the earliest on the edge that leaves RESP.
REQ-029 Latency from the acceptance edge to rsp_valid high SHALL be: error 1 cycle, load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
REQ-030 mem_wren SHALL be 1 only in WRITE, and mem_wread SHALL be 1 only in READ.
REQ-031 mem_address SHALL equal the latched word index outside IDLE and 0 in IDLE.
REQ-032 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-033 While reset_n=0 the unit SHALL asynchronously set the state to IDLE, and all outputs and registers to 0, except req_ready=1 after reset deasserts.
REQ-034 Reset asserted in WRITE SHALL drop mem_wren combinationally, abandon the write before the next edge, and produce no response.
REQ-035 After reset_n rises, the first request SHALL be accepted on the next posedge with req_valid=1.

Verification
REQ-036 The bench SHALL cover a word store/load: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_error 0, rsp_valid 2 cycles after accept; RAM word 4 = 0xDEADBEEF.
REQ-037 The bench SHALL cover byte-lane merge: word 4 = 0xDEADBEEF, then SB addr 0x12 data 0x55 -> word 4 = 0xDE55BEEF, rsp_valid 3 cycles after accept, mem_wren high exactly one cycle.
REQ-038 The bench SHALL cover extension: word 4 = 0xDE55BEEF, then LB 0x11 -> 0xFFFFFFBE, LBU 0x11 -> 0x000000BE, LH 0x12 -> 0xFFFFDE55, LHU 0x12 -> 0x0000DE55.
REQ-039 The bench SHALL cover errors: LW 0x13, SH 0x11, funct3 011, SBU (write=1 with funct3 100), and LW 0x1000 (mem_depth 1024) -> rsp_error 1 after 1 cycle, mem_wren/mem_wread never high, RAM contents unchanged.
REQ-040 The bench SHALL cover back-to-back: req_valid held high with two loads -> second accepted on the edge leaving RESP, req_ready low during READ and RESP.
REQ-041 The bench SHALL cover reset mid-write: reset_n low during WRITE of SW 0x20 data 0x12345678 -> mem_wren 0 immediately, word 8 unchanged, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core request/response and RAM port bundle for the load/store unit.
// The slave modport is the unit's view; master is the core/RAM environment.
interface load_store_unit_if #(
  parameter int unsigned size = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [size-1:0] req_addr;
  logic [size-1:0] req_wdata;
  logic [2:0]      req_funct3;
  logic            rsp_valid;
  logic [size-1:0] rsp_rdata;
  logic            rsp_error;
  logic [size-1:0] mem_address;
  logic [size-1:0] mem_data;
  logic            mem_wren;
  logic            mem_wread;
  logic [size-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_data, mem_wren, mem_wread
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_address, mem_data, mem_wren, mem_wread
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word RAM
// with sub-word store read-modify-write, alignment and range checking.
module load_store_unit #(
  parameter int unsigned mem_depth = 1024,
  parameter int unsigned size      = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  localparam int unsigned idx_w = size - 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state, state_n;

  logic [size-1:0] addr_q;
  logic [15:0]     wdata_q;
  logic [2:0]      funct3_q;
  logic            write_q;

  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_error_q;
  logic [size-1:0] rsp_rdata_q;
  logic [size-1:0] mem_address_q;
  logic [size-1:0] mem_data_q;
  logic            mem_wren_q;
  logic            mem_wread_q;

  logic            accept_c;
  logic            req_err_c;
  logic [4:0]      lane_sh_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [size-1:0] load_c;
  logic [size-1:0] lane_mask_c;
  logic [size-1:0] merged_c;

  assign accept_c = (state == IDLE) && bus.req_valid && req_ready_q;

  // Reject misaligned, unsupported-encoding and out-of-range requests up front.
  always_comb begin
    req_err_c = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err_c = 1'b0;
      3'b001:  req_err_c = bus.req_addr[0];
      3'b010:  req_err_c = |bus.req_addr[1:0];
      3'b100:  req_err_c = bus.req_write;
      3'b101:  req_err_c = bus.req_write | bus.req_addr[0];
      default: req_err_c = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[size-1:2]} >= size'(mem_depth)) begin
      req_err_c = 1'b1;
    end
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    lane_sh_c   = {addr_q[1:0], 3'b000};
    byte_c      = 8'(bus.mem_rdata >> lane_sh_c);
    half_c      = 16'(bus.mem_rdata >> lane_sh_c);
    case (funct3_q)
      3'b000:  load_c = {{(size-8){byte_c[7]}}, byte_c};
      3'b001:  load_c = {{(size-16){half_c[15]}}, half_c};
      3'b100:  load_c = size'(byte_c);
      3'b101:  load_c = size'(half_c);
      default: load_c = bus.mem_rdata;
    endcase
    lane_mask_c = size'(funct3_q[0] ? 16'hFFFF : 16'h00FF) << lane_sh_c;
    merged_c    = (bus.mem_rdata & ~lane_mask_c) |
                  ((size'(wdata_q) << lane_sh_c) & lane_mask_c);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c) begin
            state_n = RESP;
          end else if (!bus.req_write || (bus.req_funct3 != 3'b010)) begin
            state_n = READ;
          end else begin
            state_n = WRITE;
          end
        end
      end
      READ:    state_n = write_q ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request capture at the acceptance edge; inputs are ignored otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
    end else if (accept_c) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata[15:0];
      funct3_q <= bus.req_funct3;
      write_q  <= bus.req_write;
    end
  end

  // Outputs are registered from the next state so each tracks its state exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_wread_q   <= 1'b0;
    end else begin
      req_ready_q <= (state_n == IDLE);
      rsp_valid_q <= (state_n == RESP);
      rsp_error_q <= (state == IDLE) && (state_n == RESP);
      rsp_rdata_q <= ((state == READ) && !write_q) ? load_c : '0;
      mem_wren_q  <= (state_n == WRITE);
      mem_wread_q <= (state_n == READ);
      if (state_n == IDLE) begin
        mem_address_q <= '0;
      end else if (state == IDLE) begin
        mem_address_q <= size'(bus.req_addr[size-1:2]);
      end else begin
        mem_address_q <= size'(addr_q[size-1:2]);
      end
      if (state_n == WRITE) begin
        mem_data_q <= (state == IDLE) ? bus.req_wdata : merged_c;
      end else begin
        mem_data_q <= '0;
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_wread   = mem_wread_q;

endmodule
